mips_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS datapath: holds the PC and issues one word request at a time to instruction memory.
- Captures the returned instruction and presents it to decode with a valid/ready handshake.
- Splits the instruction into its R/I fields; id_imm16 drives the 16-to-32 sign extender directly.
- Handles branch/jump redirects, including discarding in-flight responses.

---
 rtl/mips_fetch_pkg.sv | 31 +++
 rtl/mips_instr_fields.sv | 23 ++
 rtl/mips_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_mips_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// The HALT state only exists when MIPS_FETCH_MISALIGN_TRAP_EN is defined.
package mips_fetch_pkg;

    `ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {REQ, WAIT, FULL, DROP, HALT} fetch_state_t;
    `else
    typedef enum logic [2:0] {REQ, WAIT, FULL, DROP} fetch_state_t;
    `endif

    // Instruction field bit positions
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    // Default fetch parameters
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/mips_instr_fields.sv
// Combinational splitter of a 32-bit MIPS instruction into its R/I fields.
module mips_instr_fields
    import mips_fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding imem request,
// instruction hold register with valid/ready handshake to decode, and
// branch/jump redirect handling with in-flight response discard.
// Optional: MIPS_FETCH_MISALIGN_TRAP_EN adds misalign_err and a HALT state.
module mips_fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    fetch_state_t state, stateNext;
    logic [31:0]  pc, pcNext;
    logic [31:0]  idPc, idInstr;
    logic         capture;
    logic [31:0]  redirectAligned;

    // Masking keeps every redirect_pc bit in use even when the trap is off
    assign redirectAligned = redirect_pc & ~32'd3;

`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    logic errQ, errNext;
    assign misalign_err = errQ;
`endif

    // State, PC and instruction-hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ;
            pc      <= RESET_PC;
            idPc    <= '0;
            idInstr <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            if (capture) begin
                idPc    <= pc;
                idInstr <= imem_rsp_data;
            end
        end
    end

`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) errQ <= 1'b0;
        else     errQ <= errNext;
    end
`endif

    // Next-state logic; redirect outranks every handshake
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        capture   = 1'b0;
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
        errNext   = errQ;
`endif
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
        if (state == HALT) begin
            stateNext = HALT;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            stateNext = HALT;
            errNext   = 1'b1;
        end else
`endif
        if (redirect_valid) begin
            pcNext = redirectAligned;
            case (state)
                REQ:     stateNext = imem_req_ready ? DROP : REQ;
                WAIT:    stateNext = imem_rsp_valid ? REQ : DROP;
                FULL:    stateNext = REQ;
                DROP:    stateNext = DROP;
                default: stateNext = state;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) stateNext = WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        capture   = 1'b1;
                        pcNext    = pc + PC_STEP;
                        stateNext = FULL;
                    end
                end
                FULL: begin
                    if (id_ready) stateNext = REQ;
                end
                DROP: begin
                    if (imem_rsp_valid) stateNext = REQ;
                end
                default: stateNext = state;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_req_addr  = pc;
    assign id_valid       = (state == FULL);
    assign id_pc          = idPc;
    assign id_instr       = idInstr;

    mips_instr_fields u_fields (
        .instr  (idInstr),
        .opcode (id_opcode),
        .rs     (id_rs),
        .rt     (id_rt),
        .rd     (id_rd),
        .shamt  (id_shamt),
        .funct  (id_funct),
        .imm16  (id_imm16)
    );

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed, table-driven bench for mips_fetch_stage. Each vector holds the
// inputs for one cycle and the outputs expected before that cycle's edge.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    mips_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_funct       (id_funct),
        .id_imm16       (id_imm16)
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        idr;
        logic        erv;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] eipc;
        logic [31:0] eins;
    } vec_t;

    vec_t tabA[$];
    vec_t tabB[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic r, logic rdy, logic rsp, logic [31:0] data,
                                logic redir, logic [31:0] rpc, logic idr,
                                logic erv, logic [31:0] eaddr, logic eiv,
                                logic [31:0] eipc, logic [31:0] eins);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rsp = rsp; v.data = data;
        v.redir = redir; v.rpc = rpc; v.idr = idr;
        v.erv = erv; v.eaddr = eaddr; v.eiv = eiv; v.eipc = eipc; v.eins = eins;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and check settled outputs
    task automatic apply(vec_t v, string tag);
        logic [31:0] ins;
        @(negedge clk);
        rst            = v.rst;
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rsp;
        imem_rsp_data  = v.data;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        id_ready       = v.idr;
        #1;
        ins = v.eins;
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v.erv});
        chk({tag, ".req_addr"},  imem_req_addr, v.eaddr);
        chk({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, v.eiv});
        chk({tag, ".id_pc"},     id_pc, v.eipc);
        chk({tag, ".id_instr"},  id_instr, v.eins);
        chk({tag, ".opcode"},    {26'd0, id_opcode}, {26'd0, ins[31:26]});
        chk({tag, ".rs"},        {27'd0, id_rs},     {27'd0, ins[25:21]});
        chk({tag, ".rt"},        {27'd0, id_rt},     {27'd0, ins[20:16]});
        chk({tag, ".rd"},        {27'd0, id_rd},     {27'd0, ins[15:11]});
        chk({tag, ".shamt"},     {27'd0, id_shamt},  {27'd0, ins[10:6]});
        chk({tag, ".funct"},     {26'd0, id_funct},  {26'd0, ins[5:0]});
        chk({tag, ".imm16"},     {16'd0, id_imm16},  {16'd0, ins[15:0]});
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Reset and first fetch of 2008FFFF
        //                   rst rdy rsp data           rdr rpc            idr  erv eaddr          eiv eipc           eins
        tabA.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0));
        tabA.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0));
        tabA.push_back(mk(0, 1, 1, 32'h2008FFFF,  0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         32'h0));

        // Release, redirect in WAIT, redirect in FULL, wrap, mid-run reset
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h4,         1, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h4,         0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 0, 0, 32'h0,         1, 32'h100,       0,   0, 32'h4,         0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h100,       0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 0, 1, 32'hDEADBEEF,  0, 32'h0,         0,   0, 32'h100,       0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h100,       0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 0, 1, 32'h8C220004,  0, 32'h0,         0,   0, 32'h100,       0, 32'h0,         32'h2008FFFF));
        tabB.push_back(mk(0, 0, 0, 32'h0,         1, 32'h200,       1,   0, 32'h104,       1, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h200,       0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 0, 0, 32'h0,         1, 32'h300,       0,   1, 32'h200,       0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 1, 0, 32'h0,         1, 32'hFFFFFFFC,  0,   1, 32'h300,       0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 0, 1, 32'h11111111,  0, 32'h0,         0,   0, 32'hFFFFFFFC,  0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'hFFFFFFFC,  0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 0, 1, 32'h00851020,  0, 32'h0,         0,   0, 32'hFFFFFFFC,  0, 32'h100,       32'h8C220004));
        tabB.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(0, 0, 1, 32'h22222222,  1, 32'h40,        0,   0, 32'h0,         0, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h40,        0, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h40,        0, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         0,   0, 32'h40,        0, 32'hFFFFFFFC,  32'h00851020));
        tabB.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         32'h0));

        @(negedge clk);
        @(negedge clk);

        foreach (tabA[i]) apply(tabA[i], $sformatf("a%0d", i));

        // Decode stalls for 10 cycles: outputs must hold, no new request
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h4, 1, 32'h0, 32'h2008FFFF),
                  $sformatf("hold%0d", i));
            if (i == 0) begin
                chk("t1.opcode", {26'd0, id_opcode}, 32'h08);
                chk("t1.rt",     {27'd0, id_rt},     32'd8);
                chk("t1.imm16",  {16'd0, id_imm16},  32'hFFFF);
                chk("t1.rs",     {27'd0, id_rs},     32'd0);
            end
        end

        foreach (tabB[i]) apply(tabB[i], $sformatf("b%0d", i));

        // Misaligned redirect from REQ at pc 0
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
        apply(mk(0, 0, 0, 32'h0, 1, 32'h102, 0, 1, 32'h0, 0, 32'h0, 32'h0), "mis0");
        chk("mis0.err", {31'd0, misalign_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, 1, 1, 32'h12345678, 1, 32'h200, 1, 0, 32'h0, 0, 32'h0, 32'h0),
                  $sformatf("halt%0d", i));
            chk($sformatf("halt%0d.err", i), {31'd0, misalign_err}, 32'd1);
        end
        apply(mk(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0), "halt_rst");
        chk("halt_rst.err", {31'd0, misalign_err}, 32'd1);
        apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 32'h0), "post_rst");
        chk("post_rst.err", {31'd0, misalign_err}, 32'd0);
`else
        apply(mk(0, 0, 0, 32'h0, 1, 32'h102, 0, 1, 32'h0, 0, 32'h0, 32'h0), "mis0");
        apply(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h100, 0, 32'h0, 32'h0), "mis1");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
